// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package serial_add_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_ripple_adder_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  assign sum      = a ^ b ^ carryin;
  assign carryout = (a & b) | (carryin & (a ^ b));

endmodule

// File: rtl/serial_ripple_adder.sv
// Bit-serial WIDTH-bit adder built around a single fa_cell, one bit pair per clock, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output captured with the result.
module serial_ripple_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_badWidth
    $error("serial_ripple_adder: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sumSh_q, sumSh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             cellSum, cellCarry;
  logic [WIDTH-1:0] sumShNext;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_cell u_faCell (
    .a        (aSh_q[0]),
    .b        (bSh_q[0]),
    .carryin  (carry_q),
    .sum      (cellSum),
    .carryout (cellCarry)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 lands in position 0.
  assign sumShNext = (sumSh_q >> 1) | (WIDTH'(cellSum) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          aSh_d   = a;
          bSh_d   = b;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        sumSh_d = sumShNext;
        carry_d = cellCarry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = sumShNext;
          cout_d  = cellCarry;
`ifdef SERIAL_ADD_OVF_EN
          // On the MSB cycle carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ cellCarry;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Self-checking bench for serial_ripple_adder at WIDTH=1, 8 and 32 against an arithmetic reference.
// Overflow checks are compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_serial_ripple_adder;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  logic        start8 = 1'b0, cin8 = 1'b0, ready8, done8, cout8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        start1 = 1'b0, cin1 = 1'b0, ready1, done1, cout1;
  logic [0:0]  a1 = '0, b1 = '0, sum1;
  logic        start32 = 1'b0, cin32 = 1'b0, ready32, done32, cout32;
  logic [31:0] a32 = '0, b32 = '0, sum32;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf1, ovf32;
`endif

  serial_ripple_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
    , .overflow(ovf8)
`endif
  );

  serial_ripple_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .overflow(ovf1)
`endif
  );

  serial_ripple_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .ready(ready32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef SERIAL_ADD_OVF_EN
    , .overflow(ovf32)
`endif
  );

  // {cout,sum} for a w-bit add, straight from integer arithmetic.
  function automatic logic [32:0] refAdd(int w, logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] mask, full;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, c};
    return full & ((mask << 1) | 33'd1);
  endfunction

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic refOvf(int w, logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] r;
    r = refAdd(w, x, y, c);
    return (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 add from a ready state and wait (bounded) for done.
  task automatic runOp8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output logic [7:0] s, output logic co, output int lat);
    bit seen;
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (done8) seen = 1;
    end
    if (!seen) lat = -1;
    s = sum8;
    co = cout8;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nChecks++; if (ready8 !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", ready8); else nPass++;
    nChecks++; if (done8 !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done8); else nPass++;
    nChecks++; if (sum8 !== 8'h00) $display("[TB] FAIL reset_sum got %h want 00", sum8); else nPass++;
    nChecks++; if (cout8 !== 1'b0) $display("[TB] FAIL reset_cout got %b want 0", cout8); else nPass++;
`ifdef SERIAL_ADD_OVF_EN
    nChecks++; if (ovf8 !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", ovf8); else nPass++;
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic co;
    int lat;
    runOp8(8'h0F, 8'h01, 1'b0, s, co, lat);
    nChecks++; if (lat !== 8) $display("[TB] FAIL basic_latency got %0d want 8", lat); else nPass++;
    nChecks++; if (s !== 8'h10) $display("[TB] FAIL basic_sum got %h want 10", s); else nPass++;
    nChecks++; if (co !== 1'b0) $display("[TB] FAIL basic_cout got %b want 0", co); else nPass++;
    tick();
    runOp8(8'hFF, 8'h01, 1'b0, s, co, lat);
    nChecks++; if ({co, s} !== 9'h100) $display("[TB] FAIL wrap_result got %h want 100", {co, s}); else nPass++;
    runOp8(8'hFF, 8'hFF, 1'b1, s, co, lat);
    nChecks++; if ({co, s} !== 9'h1FF) $display("[TB] FAIL max_result got %h want 1ff", {co, s}); else nPass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    bit seen;
    bit stable;
    a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h80; b8 = 8'h90; cin8 = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      tick(); lat++;
      if (done8) seen = 1;
    end
    nChecks++; if (!seen || lat != 8) $display("[TB] FAIL b2b_first_latency got %0d want 8", seen ? lat : -1); else nPass++;
    nChecks++; if ({cout8, sum8} !== 9'h034) $display("[TB] FAIL b2b_first_result got %h want 034", {cout8, sum8}); else nPass++;
    gap = 0; seen = 0; stable = 1;
    while (!seen && gap < 40) begin
      tick(); gap++;
      if (done8) seen = 1;
      else if ({cout8, sum8} !== 9'h034) stable = 0;
    end
    start8 = 1'b0;
    nChecks++; if (!seen || gap != 9) $display("[TB] FAIL b2b_done_spacing got %0d want 9", seen ? gap : -1); else nPass++;
    nChecks++; if (stable !== 1'b1) $display("[TB] FAIL b2b_sum_stable got %b want 1", stable); else nPass++;
    nChecks++; if ({cout8, sum8} !== 9'h111) $display("[TB] FAIL b2b_second_result got %h want 111", {cout8, sum8}); else nPass++;
    tick();
  endtask

  task automatic test_ignore_busy_start();
    int lat;
    bit seen;
    bit extraDone;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    repeat (3) begin tick(); lat++; end
    a8 = 8'hAA; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
    tick(); lat++;
    start8 = 1'b0;
    seen = 0;
    while (!seen && lat < 40) begin
      tick(); lat++;
      if (done8) seen = 1;
    end
    nChecks++; if (!seen || lat != 8) $display("[TB] FAIL ignore_latency got %0d want 8", seen ? lat : -1); else nPass++;
    nChecks++; if ({cout8, sum8} !== 9'h047) $display("[TB] FAIL ignore_result got %h want 047", {cout8, sum8}); else nPass++;
    extraDone = 0;
    repeat (12) begin tick(); if (done8) extraDone = 1; end
    nChecks++; if (extraDone !== 1'b0) $display("[TB] FAIL ignore_no_second_done got %b want 0", extraDone); else nPass++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] s;
    logic co;
    int lat;
    bit sawDone;
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    nChecks++; if (ready8 !== 1'b1) $display("[TB] FAIL abort_ready got %b want 1", ready8); else nPass++;
    nChecks++; if (sum8 !== 8'h00) $display("[TB] FAIL abort_sum got %h want 00", sum8); else nPass++;
    tick();
    reset = 1'b0;
    sawDone = 0;
    repeat (12) begin tick(); if (done8) sawDone = 1; end
    nChecks++; if (sawDone !== 1'b0) $display("[TB] FAIL abort_no_done got %b want 0", sawDone); else nPass++;
    runOp8(8'h03, 8'h04, 1'b0, s, co, lat);
    nChecks++; if (lat !== 8 || {co, s} !== 9'h007) $display("[TB] FAIL abort_recover got lat %0d res %h want lat 8 res 007", lat, {co, s}); else nPass++;
    tick();
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_overflow();
    logic [7:0] s;
    logic co;
    int lat;
    runOp8(8'h7F, 8'h01, 1'b0, s, co, lat);
    nChecks++; if (ovf8 !== 1'b1) $display("[TB] FAIL ovf_pos got %b want 1", ovf8); else nPass++;
    runOp8(8'h80, 8'hFF, 1'b0, s, co, lat);
    nChecks++; if (ovf8 !== 1'b1) $display("[TB] FAIL ovf_neg got %b want 1", ovf8); else nPass++;
    runOp8(8'h05, 8'h03, 1'b0, s, co, lat);
    nChecks++; if (ovf8 !== 1'b0) $display("[TB] FAIL ovf_none got %b want 0", ovf8); else nPass++;
    tick();
  endtask
`endif

  // All three widths run concurrently, each op launched together and checked on its own done.
  task automatic test_random();
    logic [31:0] x1, y1, x8, y8, x32, y32;
    logic c1, c8, c32;
    logic [32:0] r1, r8, r32, e1, e8, e32;
    logic o1, o8, o32;
    int l1, l8, l32, k;
    for (int op = 0; op < 1000; op++) begin
      x1 = 32'($urandom_range(0, 1)); y1 = 32'($urandom_range(0, 1)); c1 = 1'($urandom);
      x8 = {24'd0, 8'($urandom)}; y8 = {24'd0, 8'($urandom)}; c8 = 1'($urandom);
      x32 = $urandom; y32 = $urandom; c32 = 1'($urandom);
      if (op % 50 == 0) begin x32 = 32'hFFFF_FFFF; y32 = 32'h0000_0001; end
      a1 = x1[0:0]; b1 = y1[0:0]; cin1 = c1; start1 = 1'b1;
      a8 = x8[7:0]; b8 = y8[7:0]; cin8 = c8; start8 = 1'b1;
      a32 = x32; b32 = y32; cin32 = c32; start32 = 1'b1;
      tick();
      start1 = 1'b0; start8 = 1'b0; start32 = 1'b0;
      a1 = 1'($urandom); a8 = 8'($urandom); a32 = $urandom;
      l1 = -1; l8 = -1; l32 = -1; k = 0;
      r1 = '0; r8 = '0; r32 = '0; o1 = 0; o8 = 0; o32 = 0;
      while ((l1 < 0 || l8 < 0 || l32 < 0) && k < 40) begin
        tick(); k++;
        if (done1 && l1 < 0) begin
          l1 = k; r1 = {31'd0, cout1, sum1};
`ifdef SERIAL_ADD_OVF_EN
          o1 = ovf1;
`endif
        end
        if (done8 && l8 < 0) begin
          l8 = k; r8 = {24'd0, cout8, sum8};
`ifdef SERIAL_ADD_OVF_EN
          o8 = ovf8;
`endif
        end
        if (done32 && l32 < 0) begin
          l32 = k; r32 = {cout32, sum32};
`ifdef SERIAL_ADD_OVF_EN
          o32 = ovf32;
`endif
        end
      end
      e1 = refAdd(1, x1, y1, c1);
      e8 = refAdd(8, x8, y8, c8);
      e32 = refAdd(WIDTH_MAX, x32, y32, c32);
      nChecks++; if (l1 != 1) $display("[TB] FAIL rnd_w1_latency op %0d got %0d want 1", op, l1); else nPass++;
      nChecks++; if (r1 !== e1) $display("[TB] FAIL rnd_w1_result op %0d got %h want %h", op, r1, e1); else nPass++;
      nChecks++; if (l8 != 8) $display("[TB] FAIL rnd_w8_latency op %0d got %0d want 8", op, l8); else nPass++;
      nChecks++; if (r8 !== e8) $display("[TB] FAIL rnd_w8_result op %0d got %h want %h", op, r8, e8); else nPass++;
      nChecks++; if (l32 != 32) $display("[TB] FAIL rnd_w32_latency op %0d got %0d want 32", op, l32); else nPass++;
      nChecks++; if (r32 !== e32) $display("[TB] FAIL rnd_w32_result op %0d got %h want %h", op, r32, e32); else nPass++;
`ifdef SERIAL_ADD_OVF_EN
      nChecks++; if (o1 !== refOvf(1, x1, y1, c1)) $display("[TB] FAIL rnd_w1_ovf op %0d got %b", op, o1); else nPass++;
      nChecks++; if (o8 !== refOvf(8, x8, y8, c8)) $display("[TB] FAIL rnd_w8_ovf op %0d got %b", op, o8); else nPass++;
      nChecks++; if (o32 !== refOvf(32, x32, y32, c32)) $display("[TB] FAIL rnd_w32_ovf op %0d got %b", op, o32); else nPass++;
`else
      o1 = refOvf(1, x1, y1, c1) ^ o1 ^ o8 ^ o32;
`endif
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before the end of the test sequence");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy_start();
    test_reset_abort();
`ifdef SERIAL_ADD_OVF_EN
    test_overflow();
`endif
    test_random();
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
